// File: rtl/alu_bist_ctrl.sv
// Built-in self-test sequencer for a fault-tolerant ALU: applies Galois-LFSR
// patterns, strobes the signature checker, and tracks pass/fail history.
module alu_bist_ctrl #(
   parameter int unsigned N_PATTERNS = 32'd256,
   parameter logic [31:0] SEED       = 32'hACE1ACE1,
   parameter int unsigned INTERVAL   = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        periodic_en,
   input  logic        stall,
   input  logic        fault_in,
   output logic        test_en,
   output logic        test_done,
   output logic [31:0] lfsr_out,
   output logic        busy,
   output logic        pass,
   output logic        fail,
   output logic [7:0]  run_count
);

   localparam logic [15:0] PAT_LAST  = 16'(N_PATTERNS - 32'd1);
   localparam logic [15:0] INT_LAST  = 16'(INTERVAL - 32'd1);
   localparam logic [31:0] LFSR_POLY = 32'h80200003;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_SIGN  = 2'd2,
      ST_CHECK = 2'd3
   } state_t;

   function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
      return (cur >> 1) ^ (cur[0] ? LFSR_POLY : 32'h0000_0000);
   endfunction

   state_t      state_r, state_s;
   logic [15:0] pat_cnt_r, pat_cnt_s;
   logic [15:0] int_cnt_r, int_cnt_s;
   logic [31:0] lfsr_r, lfsr_s;
   logic        pass_r, pass_s;
   logic        fail_r, fail_s;
   logic [7:0]  run_cnt_r, run_cnt_s;
   logic        test_done_r;
   logic        busy_r;
   logic        expire_s;

   // Interval expiry is only meaningful while idle with periodic testing enabled.
   assign expire_s  = periodic_en && (int_cnt_r == INT_LAST);

   assign test_en   = (state_r == ST_RUN) && !stall;
   assign test_done = test_done_r;
   assign lfsr_out  = lfsr_r;
   assign busy      = busy_r;
   assign pass      = pass_r;
   assign fail      = fail_r;
   assign run_count = run_cnt_r;

   // Next-state, counter and status computation.
   always_comb begin
      state_s   = state_r;
      pat_cnt_s = pat_cnt_r;
      int_cnt_s = int_cnt_r;
      lfsr_s    = lfsr_r;
      pass_s    = pass_r;
      fail_s    = fail_r;
      run_cnt_s = run_cnt_r;
      case (state_r)
         ST_IDLE: begin
            // A coincident start and expiry still launch a single session.
            if (start || (expire_s && !fail_r)) begin
               state_s   = ST_RUN;
               lfsr_s    = SEED;
               pat_cnt_s = 16'd0;
               int_cnt_s = 16'd0;
               pass_s    = 1'b0;
            end else if (!periodic_en || expire_s) begin
               int_cnt_s = 16'd0;
            end else begin
               int_cnt_s = int_cnt_r + 16'd1;
            end
         end
         ST_RUN: begin
            if (!stall) begin
               lfsr_s = lfsr_step(lfsr_r);
               if (pat_cnt_r == PAT_LAST) begin
                  pat_cnt_s = 16'd0;
                  state_s   = ST_SIGN;
               end else begin
                  pat_cnt_s = pat_cnt_r + 16'd1;
               end
            end else begin
               pat_cnt_s = pat_cnt_r;
            end
         end
         ST_SIGN: begin
            state_s = ST_CHECK;
         end
         ST_CHECK: begin
            state_s = ST_IDLE;
            if (fault_in) begin
               fail_s = 1'b1;
               pass_s = 1'b0;
            end else begin
               pass_s = 1'b1;
            end
            if (run_cnt_r != 8'hFF) begin
               run_cnt_s = run_cnt_r + 8'd1;
            end else begin
               run_cnt_s = run_cnt_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         pat_cnt_r   <= 16'd0;
         int_cnt_r   <= 16'd0;
         lfsr_r      <= SEED;
         pass_r      <= 1'b0;
         fail_r      <= 1'b0;
         run_cnt_r   <= 8'd0;
         test_done_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         pat_cnt_r   <= pat_cnt_s;
         int_cnt_r   <= int_cnt_s;
         lfsr_r      <= lfsr_s;
         pass_r      <= pass_s;
         fail_r      <= fail_s;
         run_cnt_r   <= run_cnt_s;
         test_done_r <= (state_s == ST_SIGN);
         busy_r      <= (state_s != ST_IDLE);
      end
   end

endmodule
